// File: rtl/axi_lite_arbiter_pkg.sv
// AxiArbStruct: shared types for the two-master AXI-lite arbiter.
// Holds the write/read FSM state encodings and the one-hot grant constants
// used by axi_lite_arbiter and rr_arbiter2.
package AxiArbStruct;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // One-hot owner encoding, bit 0 = m0, bit 1 = m1.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/axi_lite_arbiter_rr.sv
// rr_arbiter2: 2-way grant selection with a round-robin preference pointer.
// Ports: clk, rstn; req (bit0=m0, bit1=m1); done pulses when the owner's
// transaction completes; owner = current grant; grant = combinational pick.
// Macro AXI_ARB_FIXED_PRIO_EN: m0 always wins, no pointer register.
module rr_arbiter2
  import AxiArbStruct::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       done,
  input  logic [1:0] owner,
  output logic [1:0] grant
);

`ifdef AXI_ARB_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = ^{clk, rstn, done, owner};

  always_comb begin
    grant = GRANT_NONE;
    if (req[0])      grant = GRANT_M0;
    else if (req[1]) grant = GRANT_M1;
  end

`else

  // ptr = 0 prefers m0, ptr = 1 prefers m1.
  logic ptr;

  // After a completed transaction, prefer the master that was not served.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     ptr <= 1'b0;
    else if (done) ptr <= owner[0];
  end

  always_comb begin
    grant = GRANT_NONE;
    case (req)
      2'b01:   grant = GRANT_M0;
      2'b10:   grant = GRANT_M1;
      2'b11:   grant = ptr ? GRANT_M1 : GRANT_M0;
      default: grant = GRANT_NONE;
    endcase
  end

`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI-lite slave path (s_*) between two masters
// (m0_* = core, m1_* = secondary). Read and write channels are arbitrated
// independently, one outstanding transaction each; grant costs one cycle.
// Ports: clk, rstn (async active-low), m0_*/m1_* slave-side AXI-lite,
// s_* master-side AXI-lite, wr_grant/rd_grant one-hot owners (00 = idle).
// Macro AXI_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module axi_lite_arbiter
  import AxiArbStruct::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  // master 0
  input  logic [AXI_ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic                        m0_awvalid,
  output logic                        m0_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   m0_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                        m0_wvalid,
  output logic                        m0_wready,
  output logic [1:0]                  m0_bresp,
  output logic                        m0_bvalid,
  input  logic                        m0_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   m0_araddr,
  input  logic                        m0_arvalid,
  output logic                        m0_arready,
  output logic [AXI_DATA_WIDTH-1:0]   m0_rdata,
  output logic [1:0]                  m0_rresp,
  output logic                        m0_rvalid,
  input  logic                        m0_rready,
  // master 1
  input  logic [AXI_ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic                        m1_awvalid,
  output logic                        m1_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   m1_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                        m1_wvalid,
  output logic                        m1_wready,
  output logic [1:0]                  m1_bresp,
  output logic                        m1_bvalid,
  input  logic                        m1_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   m1_araddr,
  input  logic                        m1_arvalid,
  output logic                        m1_arready,
  output logic [AXI_DATA_WIDTH-1:0]   m1_rdata,
  output logic [1:0]                  m1_rresp,
  output logic                        m1_rvalid,
  input  logic                        m1_rready,
  // shared downstream path
  output logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [AXI_DATA_WIDTH-1:0]   s_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  input  logic [1:0]                  s_bresp,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  // status
  output logic [1:0]                  wr_grant,
  output logic [1:0]                  rd_grant
);

  // ---------------------------------------------------------------- write
  wr_state_t  w_state;
  logic [1:0] w_owner;
  logic [1:0] w_req;
  logic [1:0] w_pick;
  logic       aw_done;
  logic       w_done;
  logic       in_waddr;
  logic       in_wresp;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;

  assign w_req    = {m1_awvalid, m0_awvalid};
  assign in_waddr = (w_state == W_ADDR);
  assign in_wresp = (w_state == W_RESP);
  assign aw_hs    = s_awvalid & s_awready;
  assign w_hs     = s_wvalid & s_wready;
  assign b_hs     = s_bvalid & s_bready;

  rr_arbiter2 u_wr_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (w_req),
    .done  (b_hs),
    .owner (w_owner),
    .grant (w_pick)
  );

  // AW and W may complete in either order; each flag masks its channel
  // once its handshake has happened so nothing is forwarded twice.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      w_owner <= GRANT_NONE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (|w_req) begin
            w_owner <= w_pick;
            w_state <= W_ADDR;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        W_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) && (w_done | w_hs)) w_state <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            w_owner <= GRANT_NONE;
            w_state <= W_IDLE;
          end
        end
        default: begin
          w_owner <= GRANT_NONE;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  assign s_awaddr  = w_owner[1] ? m1_awaddr : m0_awaddr;
  assign s_wdata   = w_owner[1] ? m1_wdata  : m0_wdata;
  assign s_wstrb   = w_owner[1] ? m1_wstrb  : m0_wstrb;
  assign s_awvalid = in_waddr & ~aw_done & (w_owner[1] ? m1_awvalid : m0_awvalid);
  assign s_wvalid  = in_waddr & ~w_done  & (w_owner[1] ? m1_wvalid  : m0_wvalid);
  assign s_bready  = in_wresp & (w_owner[1] ? m1_bready : m0_bready);

  assign m0_awready = in_waddr & ~aw_done & w_owner[0] & s_awready;
  assign m1_awready = in_waddr & ~aw_done & w_owner[1] & s_awready;
  assign m0_wready  = in_waddr & ~w_done  & w_owner[0] & s_wready;
  assign m1_wready  = in_waddr & ~w_done  & w_owner[1] & s_wready;
  assign m0_bvalid  = in_wresp & w_owner[0] & s_bvalid;
  assign m1_bvalid  = in_wresp & w_owner[1] & s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;
  assign wr_grant   = w_owner;

  // ----------------------------------------------------------------- read
  rd_state_t  r_state;
  logic [1:0] r_owner;
  logic [1:0] r_req;
  logic [1:0] r_pick;
  logic       in_raddr;
  logic       in_rdata;
  logic       ar_hs;
  logic       r_hs;

  assign r_req    = {m1_arvalid, m0_arvalid};
  assign in_raddr = (r_state == R_ADDR);
  assign in_rdata = (r_state == R_DATA);
  assign ar_hs    = s_arvalid & s_arready;
  assign r_hs     = s_rvalid & s_rready;

  rr_arbiter2 u_rd_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (r_req),
    .done  (r_hs),
    .owner (r_owner),
    .grant (r_pick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      r_owner <= GRANT_NONE;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (|r_req) begin
            r_owner <= r_pick;
            r_state <= R_ADDR;
          end
        end
        R_ADDR: if (ar_hs) r_state <= R_DATA;
        R_DATA: begin
          if (r_hs) begin
            r_owner <= GRANT_NONE;
            r_state <= R_IDLE;
          end
        end
        default: begin
          r_owner <= GRANT_NONE;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign s_araddr   = r_owner[1] ? m1_araddr : m0_araddr;
  assign s_arvalid  = in_raddr & (r_owner[1] ? m1_arvalid : m0_arvalid);
  assign s_rready   = in_rdata & (r_owner[1] ? m1_rready : m0_rready);

  assign m0_arready = in_raddr & r_owner[0] & s_arready;
  assign m1_arready = in_raddr & r_owner[1] & s_arready;
  assign m0_rvalid  = in_rdata & r_owner[0] & s_rvalid;
  assign m1_rvalid  = in_rdata & r_owner[1] & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;
  assign rd_grant   = r_owner;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
module tb_axi_lite_arbiter;
  import AxiArbStruct::*;

  localparam logic [63:0] K = 64'hA5A5_A5A5_0000_0000;

  logic clk = 1'b0;
  logic rstn, slv_rstn;
  always #5 clk = ~clk;

  logic [63:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [63:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [7:0]  m0_wstrb, m1_wstrb;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [1:0] m0_bresp, m1_bresp, m0_rresp, m1_rresp;
  logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [7:0]  s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0] s_bresp, s_rresp, wr_grant, rd_grant;

  axi_lite_arbiter #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
    .clk(clk), .rstn(rstn),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // ---------------- downstream slave model
  logic aw_ready_en = 1'b1;
  logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
  logic got_aw, got_w;
  int aw_cnt = 0, w_cnt = 0;
  logic [63:0] last_awaddr = '0, last_wdata = '0;
  logic [7:0]  last_wstrb = '0;

  assign s_awready = aw_ready_en;
  assign s_wready  = 1'b1;
  assign s_arready = 1'b1;
  assign s_bresp   = bresp_val;
  assign s_rresp   = rresp_val;

  always @(posedge clk or negedge slv_rstn) begin
    if (!slv_rstn) begin
      got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0;
    end else begin
      if (s_awvalid && s_awready) begin
        got_aw <= 1'b1; aw_cnt <= aw_cnt + 1; last_awaddr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        got_w <= 1'b1; w_cnt <= w_cnt + 1; last_wdata <= s_wdata; last_wstrb <= s_wstrb;
      end
      if (got_aw && got_w && !s_bvalid) begin
        s_bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1; s_rdata <= s_araddr ^ K;
      end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
    end
  end

  // ---------------- master-side bookkeeping
  int n_checks = 0, n_fail = 0, xtalk = 0;
  int m0_bcnt = 0, m1_bcnt = 0, m0_rcnt = 0, m1_rcnt = 0;
  int m0_wr_rem = 0, m1_wr_rem = 0;
  logic [1:0]  m0_bresp_r = '0, m1_bresp_r = '0, m0_rresp_r = '0;
  logic [63:0] m0_rdata_r = '0, m1_rdata_r = '0;
  logic overlap_seen = 1'b0;
  int wr_order[$];
  int rd_order[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then let the masters react.
  task automatic step();
    logic h0aw, h0w, h0b, h0ar, h0r, h1aw, h1w, h1b, h1ar, h1r;
    logic [1:0] b0, b1, r0s;
    logic [63:0] d0, d1;
    @(negedge clk);
    h0aw = m0_awvalid & m0_awready; h0w = m0_wvalid & m0_wready; h0b = m0_bvalid & m0_bready;
    h0ar = m0_arvalid & m0_arready; h0r = m0_rvalid & m0_rready;
    h1aw = m1_awvalid & m1_awready; h1w = m1_wvalid & m1_wready; h1b = m1_bvalid & m1_bready;
    h1ar = m1_arvalid & m1_arready; h1r = m1_rvalid & m1_rready;
    b0 = m0_bresp; b1 = m1_bresp; r0s = m0_rresp; d0 = m0_rdata; d1 = m1_rdata;
    if (wr_grant != GRANT_M0 && (m0_awready || m0_wready || m0_bvalid)) xtalk++;
    if (wr_grant != GRANT_M1 && (m1_awready || m1_wready || m1_bvalid)) xtalk++;
    if (rd_grant != GRANT_M0 && (m0_arready || m0_rvalid)) xtalk++;
    if (rd_grant != GRANT_M1 && (m1_arready || m1_rvalid)) xtalk++;
    if (rd_grant == 2'b01 && wr_grant == 2'b10) overlap_seen = 1'b1;
    @(posedge clk); #1;
    if (h0aw) m0_awvalid = 1'b0;
    if (h0w)  m0_wvalid  = 1'b0;
    if (h0ar) m0_arvalid = 1'b0;
    if (h1aw) m1_awvalid = 1'b0;
    if (h1w)  m1_wvalid  = 1'b0;
    if (h1ar) m1_arvalid = 1'b0;
    if (h0b) begin
      m0_bcnt++; m0_bresp_r = b0; wr_order.push_back(0);
      if (m0_wr_rem > 0) begin
        m0_wr_rem--; m0_awaddr += 8; m0_wdata += 1; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
      end
    end
    if (h1b) begin
      m1_bcnt++; m1_bresp_r = b1; wr_order.push_back(1);
      if (m1_wr_rem > 0) begin
        m1_wr_rem--; m1_awaddr += 8; m1_wdata += 1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
      end
    end
    if (h0r) begin m0_rcnt++; m0_rdata_r = d0; m0_rresp_r = r0s; rd_order.push_back(0); end
    if (h1r) begin m1_rcnt++; m1_rdata_r = d1; rd_order.push_back(1); end
  endtask

  // Bounded wait; callers check the counters afterwards.
  task automatic wait_all(input int b0, input int b1, input int r0, input int r1, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m0_bcnt >= b0 && m1_bcnt >= b1 && m0_rcnt >= r0 && m1_rcnt >= r1) break;
      step();
    end
  endtask

  logic [7:0] ord8;
  logic [7:0] exp_ord8;

  initial begin
    rstn = 1'b0; slv_rstn = 1'b0;
    m0_awaddr = '0; m0_wdata = '0; m0_wstrb = '0; m0_araddr = '0;
    m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0; m1_araddr = '0;
    m0_awvalid = 1'b1; m0_wvalid = 1'b0; m0_arvalid = 1'b0; m0_bready = 1'b1; m0_rready = 1'b1;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; m1_arvalid = 1'b1; m1_bready = 1'b1; m1_rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset: requests present but nothing forwarded or granted
    check("reset_grants", {wr_grant, rd_grant}, 4'h0);
    check("reset_s_valids", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 5'h0);
    check("reset_m_readys", {m0_awready, m0_wready, m0_arready, m0_bvalid, m0_rvalid,
                             m1_awready, m1_wready, m1_arready, m1_bvalid, m1_rvalid}, 10'h0);
    m0_awvalid = 1'b0; m1_arvalid = 1'b0;
    rstn = 1'b1; slv_rstn = 1'b1;
    step();

    // T1: single m0 write
    m0_awaddr = 64'h8000_0000; m0_wdata = 64'h1122_3344_5566_7788; m0_wstrb = 8'hFF;
    m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    check("t1_grant_not_immediate", wr_grant, 2'b00);
    step();
    check("t1_grant", wr_grant, 2'b01);
    check("t1_s_aw", {s_awvalid, s_awaddr}, {1'b1, 64'h8000_0000});
    check("t1_s_w", {s_wvalid, s_wstrb, s_wdata}, {1'b1, 8'hFF, 64'h1122_3344_5566_7788});
    check("t1_m1_quiet", {m1_awready, m1_wready, m1_bvalid}, 3'b000);
    wait_all(1, 0, 0, 0, 20);
    check("t1_bcnt", {m0_bcnt[7:0], m1_bcnt[7:0]}, {8'd1, 8'd0});
    check("t1_bresp", m0_bresp_r, 2'b00);
    check("t1_hs_counts", {aw_cnt[7:0], w_cnt[7:0]}, {8'd1, 8'd1});
    check("t1_grant_clear", wr_grant, 2'b00);

    // T2: simultaneous reads, m0 first
    m0_araddr = 64'h1000; m1_araddr = 64'h2000; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    step();
    check("t2_rd_grant", rd_grant, 2'b01);
    wait_all(1, 0, 1, 1, 30);
    check("t2_rcnt", {m0_rcnt[7:0], m1_rcnt[7:0]}, {8'd1, 8'd1});
    check("t2_order", {rd_order[0] == 0, rd_order[1] == 1}, 2'b11);
    check("t2_m0_rdata", m0_rdata_r, 64'hA5A5_A5A5_0000_1000);
    check("t2_m1_rdata", m1_rdata_r, 64'hA5A5_A5A5_0000_2000);

    // T4: m1 presents W two cycles early, slave stalls AW for 3 cycles
    aw_ready_en = 1'b0; bresp_val = 2'b01;
    m1_wdata = 64'hCAFE_F00D_DEAD_BEEF; m1_wstrb = 8'h0F; m1_wvalid = 1'b1;
    step(); step();
    check("t4_w_alone_no_grant", wr_grant, 2'b00);
    m1_awaddr = 64'h5000; m1_awvalid = 1'b1;
    step();
    check("t4_grant", wr_grant, 2'b10);
    check("t4_both_valid", {s_awvalid, s_wvalid}, 2'b11);
    step();
    check("t4_w_masked_aw_wait", {s_awvalid, s_wvalid}, 2'b10);
    step(); step();
    aw_ready_en = 1'b1;
    wait_all(1, 1, 1, 1, 20);
    check("t4_bcnt", {m0_bcnt[7:0], m1_bcnt[7:0]}, {8'd1, 8'd1});
    check("t4_bresp_pass", m1_bresp_r, 2'b01);
    check("t4_hs_counts", {aw_cnt[7:0], w_cnt[7:0]}, {8'd2, 8'd2});
    check("t4_s_addr_data", {last_awaddr, last_wdata}, {64'h5000, 64'hCAFE_F00D_DEAD_BEEF});
    check("t4_s_strb", last_wstrb, 8'h0F);
    bresp_val = 2'b00;

    // T3: 4 back-to-back writes from each master
    wr_order.delete();
    m0_awaddr = 64'h100; m0_wdata = 64'h1; m0_wr_rem = 3;
    m1_awaddr = 64'h200; m1_wdata = 64'h2; m1_wr_rem = 3;
    m0_awvalid = 1'b1; m0_wvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    wait_all(5, 5, 1, 1, 200);
    check("t3_bcnt", {m0_bcnt[7:0], m1_bcnt[7:0]}, {8'd5, 8'd5});
    check("t3_nwr", wr_order.size(), 64'd8);
    ord8 = '0;
    for (int i = 0; i < 8; i++) if (i < wr_order.size()) ord8[i] = (wr_order[i] == 1);
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_ord8 = 8'b1111_0000;
`else
    exp_ord8 = 8'b1010_1010;
`endif
    check("t3_order", ord8, exp_ord8);
    check("t3_aw_cnt", aw_cnt, 64'd10);

    // T5: concurrent m0 read and m1 write
    overlap_seen = 1'b0; rresp_val = 2'b11;
    m0_araddr = 64'h3000; m0_arvalid = 1'b1;
    m1_awaddr = 64'h4000; m1_wdata = 64'h4444; m1_wstrb = 8'hFF;
    m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    step();
    check("t5_grants", {rd_grant, wr_grant}, 4'b0110);
    wait_all(5, 6, 2, 1, 30);
    check("t5_counts", {m0_rcnt[7:0], m1_bcnt[7:0]}, {8'd2, 8'd6});
    check("t5_rdata", {m0_rresp_r, m0_rdata_r}, {2'b11, 64'hA5A5_A5A5_0000_3000});
    check("t5_waddr", last_awaddr, 64'h4000);
    check("t5_overlap", overlap_seen, 1'b1);
    rresp_val = 2'b00;

    // T6: complete one m0 write, then reset during the next one's W_RESP
    m0_awaddr = 64'h6000; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    wait_all(6, 6, 2, 1, 20);
    m0_awaddr = 64'h7000; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    step(); step(); step();
    check("t6_in_wresp", {wr_grant, m0_bvalid}, 3'b011);
    rstn = 1'b0;
    #1;
    check("t6_rst_grants", {wr_grant, rd_grant}, 4'h0);
    check("t6_rst_s", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 5'h0);
    check("t6_rst_m", {m0_bvalid, m0_awready, m0_wready, m1_bvalid, m1_awready}, 5'h0);
    slv_rstn = 1'b0;
    step(); step();
    rstn = 1'b1; slv_rstn = 1'b1;
    check("t6_no_b_forwarded", m0_bcnt, 64'd6);
    wr_order.delete();
    m0_awaddr = 64'h9000; m1_awaddr = 64'hA000;
    m0_awvalid = 1'b1; m0_wvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    m0_araddr = 64'hB000; m1_araddr = 64'hC000; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    step();
    check("t6_post_grants", {wr_grant, rd_grant}, 4'b0101);
    wait_all(7, 7, 3, 2, 60);
    check("t6_counts", {m0_bcnt[7:0], m1_bcnt[7:0], m0_rcnt[7:0], m1_rcnt[7:0]},
          {8'd7, 8'd7, 8'd3, 8'd2});
    check("t6_wr_order", {wr_order.size() == 2, wr_order[0] == 0, wr_order[1] == 1}, 3'b111);

    check("no_crosstalk", xtalk, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
